// File: rtl/axi4_slave_write_responder.sv
// AXI4 write-path subordinate: takes one AW, absorbs the W beats into a local
// word memory under byte strobes, then returns a single B response per burst.
module axi4_slave_write_responder #(
  parameter int                AXI_IW    = 4,
  parameter int                AXI_AW    = 32,
  parameter int                AXI_DW    = 32,
  parameter int                AXI_SW    = AXI_DW / 8,
  parameter int                MEM_DEPTH = 256,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [AXI_IW-1:0]            awid,
  input  logic [AXI_AW-1:0]            awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [AXI_DW-1:0]            wdata,
  input  logic [AXI_SW-1:0]            wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [AXI_IW-1:0]            bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_raddr,
  output logic [AXI_DW-1:0]            dbg_rdata
);
  localparam int LSB = $clog2(AXI_SW);
  localparam int IXW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [AXI_IW-1:0]   bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [AXI_AW-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                nowrite_q, nowrite_d;
  logic [AXI_DW-1:0]   dbg_rdata_q;

  logic [AXI_DW-1:0]   mem [MEM_DEPTH];

  logic                aw_hs, w_hs, b_hs;
  logic [AXI_AW-1:0]   aw_mask, beat_incr, wrap_mask, incr_addr, next_addr, word_off;
  logic                aw_fatal, beat_oob, final_beat, wlast_bad, mem_we;
  logic [IXW-1:0]      mem_idx;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;
  assign b_hs  = bvalid_q && bready;

  // Bursts that can never be written legally are flagged once, at AW time.
  assign aw_mask  = (AXI_AW'(1) << awsize) - AXI_AW'(1);
  assign aw_fatal = (awburst == 2'b11) || (awsize > 3'(LSB)) ||
                    ((awburst == 2'b10) &&
                     (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                      ((awaddr & aw_mask) != '0)));

  assign beat_incr = AXI_AW'(1) << size_q;
  assign wrap_mask = ((AXI_AW'(len_q) + AXI_AW'(1)) << size_q) - AXI_AW'(1);
  assign incr_addr = (addr_q & ~(beat_incr - AXI_AW'(1))) + beat_incr;

  always_comb begin
    next_addr = incr_addr;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  assign word_off   = (addr_q - BASE_ADDR) >> LSB;
  assign beat_oob   = (addr_q < BASE_ADDR) || (word_off >= AXI_AW'(MEM_DEPTH));
  assign final_beat = (cnt_q == 8'd0);
  assign wlast_bad  = (wlast != final_beat);
  assign mem_we     = w_hs && !nowrite_q && !beat_oob;
  assign mem_idx    = word_off[IXW-1:0];

  always_comb begin
    state_d   = state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    nowrite_d = nowrite_q;
    case (state_q)
      S_IDLE: if (aw_hs) begin
        state_d   = S_DATA;
        bid_d     = awid;
        addr_d    = awaddr;
        len_d     = awlen;
        size_d    = awsize;
        burst_d   = awburst;
        cnt_d     = awlen;
        err_d     = aw_fatal;
        nowrite_d = aw_fatal;
      end
      S_DATA: if (w_hs) begin
        addr_d = next_addr;
        cnt_d  = cnt_q - 8'd1;
        err_d  = err_q || beat_oob || wlast_bad;
        // Burst length comes from the beat count; wlast only feeds the error flag.
        if (final_beat) begin
          state_d = S_RESP;
          bresp_d = (err_q || beat_oob || wlast_bad) ? 2'b10 : 2'b00;
        end
      end
      S_RESP: if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      nowrite_q <= nowrite_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < AXI_SW; i++) begin
        if (wstrb[i]) mem[mem_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) dbg_rdata_q <= '0;
    else        dbg_rdata_q <= mem[dbg_raddr];
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign dbg_rdata = dbg_rdata_q;
endmodule
